// File: rtl/clock_gen_pkg.sv
// clock_gen_pkg
//   Shared definitions for the clock/strobe generator controller:
//   controller state encoding, default counter width and the smallest
//   legal half-period.
package clock_gen_pkg;

  localparam int unsigned CNT_W_DEFAULT = 16;

  // Half-period values below this are promoted to it (a half of 0 acts as 1).
  localparam int unsigned HALF_MIN = 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

endpackage

// File: rtl/clock_phase_counter.sv
// clock_phase_counter
//   Counts system clock cycles within one clk_out phase and flags the last
//   cycle of the phase.
//   Ports:
//     clock    - system clock, rising edge
//     reset_n  - asynchronous active-low reset
//     clear    - synchronous clear of the phase count (has priority)
//     enable   - advance the count this cycle
//     half     - configured half-period in cycles (0 treated as HALF_MIN)
//     wrap     - high while enabled and the count sits at half-1; the count
//                returns to zero on the same edge
module clock_phase_counter
  import clock_gen_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] half,
  output logic             wrap
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] half_eff;
  logic [CNT_W-1:0] last;

  always_comb begin
    half_eff = half;
    if (half < CNT_W'(HALF_MIN)) begin
      half_eff = CNT_W'(HALF_MIN);
    end
    last = half_eff - CNT_W'(1);
  end

  assign wrap = enable && (count == last);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (wrap) begin
        count <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/clock_gen_ctrl.sv
// clock_gen_ctrl
//   Programmable clock/strobe generator. Produces a registered, 50% duty
//   divided clock with a configurable half-period, either as a burst of N
//   periods or free-running until stopped. Runs always end with clk_out low
//   and never truncate a phase.
//   Ports:
//     clock           - system clock, rising edge
//     reset_n         - asynchronous active-low reset
//     cfg_valid       - config offer, accepted when cfg_ready is high
//     cfg_ready       - high only while idle
//     cfg_half_period - system cycles per clk_out phase (0 acts as 1)
//     cfg_cycles      - clk_out periods per run (0 = free-running)
//     start           - level-sampled start command (idle only)
//     stop            - level-sampled stop request
//     clk_out         - generated clock
//     tick            - one-cycle pulse with each clk_out rise
//     busy            - run in progress (RUN or STOPPING)
//     done            - one-cycle pulse when a run ends
module clock_gen_ctrl
  import clock_gen_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_half_period,
  input  logic [CNT_W-1:0] cfg_cycles,
  input  logic             start,
  input  logic             stop,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic             done
);

  state_t           state;
  state_t           nxt_state;
  logic [CNT_W-1:0] half_q;
  logic [CNT_W-1:0] cycles_q;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] nxt_per;
  logic             nxt_clk;
  logic             nxt_tick;
  logic             nxt_done;
  logic             cfg_load;
  logic             cnt_clear;
  logic             cnt_en;
  logic             wrap;
  logic             burst_last;

  clock_phase_counter #(
    .CNT_W (CNT_W)
  ) u_phase (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (cnt_clear),
    .enable  (cnt_en),
    .half    (half_q),
    .wrap    (wrap)
  );

  // The final period of a burst has had its rise counted once per_cnt
  // reaches the programmed count.
  assign burst_last = (cycles_q != '0) && (per_cnt == cycles_q);

  always_comb begin
    nxt_state = state;
    nxt_clk   = clk_out;
    nxt_tick  = 1'b0;
    nxt_done  = 1'b0;
    nxt_per   = per_cnt;
    cfg_load  = 1'b0;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;

    case (state)
      IDLE: begin
        cnt_clear = 1'b1;
        nxt_clk   = 1'b0;
        nxt_per   = '0;
        if (cfg_valid) begin
          cfg_load = 1'b1;
        end
        if (start && !stop) begin
          nxt_state = RUN;
        end
      end

      RUN: begin
        cnt_en = 1'b1;
        if (stop && !clk_out) begin
          // Stopping in a low phase ends the run at once; a rise due on
          // this edge is suppressed so no runt high phase appears.
          nxt_state = IDLE;
          nxt_done  = 1'b1;
          nxt_clk   = 1'b0;
        end else if (wrap) begin
          if (clk_out) begin
            nxt_clk = 1'b0;
            // A stop that lands exactly on the falling toggle finishes here
            // instead of passing through STOPPING.
            if (stop || burst_last) begin
              nxt_state = IDLE;
              nxt_done  = 1'b1;
            end
          end else begin
            nxt_clk  = 1'b1;
            nxt_tick = 1'b1;
            if (per_cnt != '1) begin
              nxt_per = per_cnt + CNT_W'(1);
            end
          end
        end else if (stop) begin
          nxt_state = STOPPING;
        end
      end

      STOPPING: begin
        cnt_en = 1'b1;
        if (wrap) begin
          nxt_clk   = 1'b0;
          nxt_done  = 1'b1;
          nxt_state = IDLE;
        end
      end

      default: begin
        nxt_state = IDLE;
        nxt_clk   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      clk_out   <= 1'b0;
      tick      <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      cfg_ready <= 1'b1;
      per_cnt   <= '0;
    end else begin
      state     <= nxt_state;
      clk_out   <= nxt_clk;
      tick      <= nxt_tick;
      done      <= nxt_done;
      busy      <= (nxt_state != IDLE);
      cfg_ready <= (nxt_state == IDLE);
      per_cnt   <= nxt_per;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      half_q   <= CNT_W'(HALF_MIN);
      cycles_q <= '0;
    end else if (cfg_load) begin
      half_q   <= cfg_half_period;
      cycles_q <= cfg_cycles;
    end
  end

endmodule

// File: tb/tb_clock_gen_ctrl.sv
// tb_clock_gen_ctrl
//   Randomized self-checking bench for clock_gen_ctrl. Expected waveforms
//   are computed per run from the relative edge index k after run entry:
//   clk_out is high when floor(k/half) is odd, rises are at odd multiples of
//   half, and the run ends at the earlier of the burst end (2*N*half) or the
//   stop point (immediately when low, else the next multiple of 2*half).
module tb_clock_gen_ctrl;
  localparam int unsigned CNT_W = 16;

  logic             clock = 1'b0;
  logic             reset_n = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_half_period = '0;
  logic [CNT_W-1:0] cfg_cycles = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             clk_out;
  logic             tick;
  logic             busy;
  logic             done;

  int errors = 0;
  int checks = 0;
  int stored_h = 1;
  int stored_n = 0;

  always #5 clock = ~clock;

  clock_gen_ctrl #(.CNT_W(CNT_W)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_half_period (cfg_half_period),
    .cfg_cycles      (cfg_cycles),
    .start           (start),
    .stop            (stop),
    .clk_out         (clk_out),
    .tick            (tick),
    .busy            (busy),
    .done            (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string where, input int e_clk, input int e_tick,
                               input int e_busy, input int e_done, input int e_ready);
    check({"clk_out ", where}, 32'(clk_out), 32'(e_clk));
    check({"tick ", where}, 32'(tick), 32'(e_tick));
    check({"busy ", where}, 32'(busy), 32'(e_busy));
    check({"done ", where}, 32'(done), 32'(e_done));
    check({"cfg_ready ", where}, 32'(cfg_ready), 32'(e_ready));
  endtask

  task automatic check_idle(input string where);
    check_outputs(where, 0, 0, 0, 0, 1);
  endtask

  function automatic int end_edge(input int he, input int n, input int ks);
    int fin;
    int fs;
    fin = (n != 0) ? 2 * n * he : 1 << 30;
    if (ks != 0) begin
      if (((ks - 1) / he) % 2 == 0) fs = ks;
      else fs = ((ks + 2 * he - 1) / (2 * he)) * 2 * he;
      if (fs < fin) fin = fs;
    end
    return fin;
  endfunction

  // Inputs for edge j of a run: stop per the plan, garbage config/start
  // offers while the DUT is busy, everything quiet once the run is over.
  task automatic drive_for_edge(input int j, input int fin, input int ks);
    stop            = (ks != 0) && (j >= ks) && (j <= fin);
    start           = (j <= fin) ? 1'($urandom % 2) : 1'b0;
    cfg_valid       = (j <= fin) ? 1'($urandom % 2) : 1'b0;
    cfg_half_period = CNT_W'($urandom);
    cfg_cycles      = CNT_W'($urandom);
  endtask

  task automatic run_case(input int h, input int n, input int ks, input bit give_cfg);
    int he;
    int fin;
    int e_busy;
    int e_clk;
    int e_tick;
    @(posedge clock); #1;
    cfg_valid       = give_cfg;
    cfg_half_period = CNT_W'(h);
    cfg_cycles      = CNT_W'(n);
    start           = 1'b1;
    stop            = 1'b0;
    if (give_cfg) begin
      stored_h = h;
      stored_n = n;
    end
    he  = (stored_h == 0) ? 1 : stored_h;
    fin = end_edge(he, stored_n, ks);
    @(posedge clock); #1;
    drive_for_edge(1, fin, ks);
    for (int k = 0; k <= fin; k++) begin
      if (k > 0) begin
        @(posedge clock); #1;
        drive_for_edge(k + 1, fin, ks);
      end
      @(negedge clock);
      e_busy = (k < fin) ? 1 : 0;
      e_clk  = e_busy ? ((k / he) % 2) : 0;
      e_tick = (e_busy && k > 0 && (k % he) == 0 && ((k / he) % 2) == 1) ? 1 : 0;
      check_outputs($sformatf("h=%0d n=%0d ks=%0d E%0d", stored_h, stored_n, ks, k),
                    e_clk, e_tick, e_busy, (k == fin) ? 1 : 0, e_busy ? 0 : 1);
    end
  endtask

  task automatic start_stop_idle();
    @(posedge clock); #1;
    start           = 1'b1;
    stop            = 1'b1;
    cfg_valid       = 1'($urandom % 2);
    cfg_half_period = CNT_W'($urandom_range(0, 5));
    cfg_cycles      = CNT_W'($urandom_range(1, 3));
    if (cfg_valid) begin
      stored_h = int'(cfg_half_period);
      stored_n = int'(cfg_cycles);
    end
    @(posedge clock); #1;
    start     = 1'b0;
    stop      = 1'b0;
    cfg_valid = 1'b0;
    @(negedge clock);
    check_idle("start+stop in idle");
  endtask

  initial begin
    int h;
    int n;
    int ks;
    int ph;
    int pn;
    int he;
    bit give;

    #1 reset_n = 1'b0;
    #2 check_idle("reset state");
    @(posedge clock); #1 reset_n = 1'b1;
    @(negedge clock);
    check_idle("after reset release");

    run_case(5, 3, 0, 1'b1);
    run_case(4, 0, 6, 1'b1);
    run_case(4, 0, 10, 1'b1);
    run_case(0, 2, 0, 1'b1);
    run_case(2, 1, 4, 1'b1);
    run_case(3, 1, 0, 1'b1);
    run_case(0, 0, 0, 1'b0);
    start_stop_idle();

    // Async reset during a high phase.
    @(posedge clock); #1;
    cfg_valid = 1'b1; cfg_half_period = CNT_W'(4); cfg_cycles = '0; start = 1'b1;
    @(posedge clock); #1;
    cfg_valid = 1'b0; start = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    check_outputs("pre-reset E4", 1, 1, 1, 0, 0);
    #2 reset_n = 1'b0;
    #1 check_idle("async reset");
    stored_h = 1;
    stored_n = 0;
    @(posedge clock); #1 reset_n = 1'b1;
    @(negedge clock);
    check_idle("after mid-run reset");
    run_case(7, 9, 5, 1'b0);

    for (int r = 0; r < 25; r++) begin
      h    = $urandom_range(0, 5);
      n    = $urandom_range(0, 3);
      give = ($urandom % 4) != 0;
      ph   = give ? h : stored_h;
      pn   = give ? n : stored_n;
      he   = (ph == 0) ? 1 : ph;
      if (pn == 0) ks = $urandom_range(1, 20);
      else ks = ($urandom % 2) ? 0 : $urandom_range(1, 2 * pn * he + 2);
      run_case(h, n, ks, give);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clock);
        @(negedge clock);
        check_idle("idle gap");
      end
      if ($urandom % 5 == 0) start_stop_idle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
